// File: rtl/idct_pkg.sv
// Shared constants and helpers for the IDCT multiply-accumulate chain.
// Holds DCT basis values, accumulator sizing and the output clamp check.
package idct_pkg;

  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_HI,
    SAT_LO
  } sat_t;

  localparam int SAT_W = 64;

  // Basis value at n=0 for each transform row k (integer HEVC-style DCT).
  localparam int DCT4_C0 [4] = '{64, 83, 64, 36};
  localparam int DCT8_C0 [8] = '{64, 89, 83, 75, 64, 50, 36, 18};
  localparam int DCT16_C0 [16] = '{64, 90, 89, 87, 83, 80, 75, 70,
                                   64, 57, 50, 43, 36, 25, 18, 9};
  localparam int DCT32_C0 [32] = '{64, 90, 90, 90, 89, 88, 87, 85,
                                   83, 82, 80, 78, 75, 73, 70, 67,
                                   64, 61, 57, 54, 50, 46, 43, 38,
                                   36, 31, 25, 22, 18, 13, 9, 4};

  function automatic int acc_w(input int n, input int dw, input int cw);
    return dw + cw + $clog2(n) + 1;
  endfunction

  // Classifies a sign-extended result against the signed dw-bit range.
  function automatic sat_t sat_check(input logic signed [SAT_W-1:0] v,
                                     input int dw, input logic sat_en);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (!sat_en) return SAT_NONE;
    if (v > hi) return SAT_HI;
    if (v < lo) return SAT_LO;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/idct_mac_stage.sv
// One systolic MAC register stage: adds the gated product of the skewed
// sample and its coefficient onto the incoming partial sum.
module idct_mac_stage #(
  parameter int DW = 25,
  parameter int CW = 8,
  parameter int AW = 37
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic signed [AW-1:0] acc_in,
  input  logic signed [DW-1:0] sample,
  input  logic signed [CW-1:0] coef,
  input  logic                 vld_in,
  output logic signed [AW-1:0] acc_out,
  output logic                 vld_out
);

  localparam int PW = DW + CW;

  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 vld_q, vld_d;

  assign prod = sample * coef;

  always_comb begin
    acc_d = acc_q;
    vld_d = vld_q;
    if (en) begin
      vld_d = vld_in;
      acc_d = acc_in + (vld_in ? {{(AW-PW){prod[PW-1]}}, prod} : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      vld_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      vld_q <= vld_d;
    end
  end

  assign acc_out = acc_q;
  assign vld_out = vld_q;

endmodule

// File: rtl/idct_mac_chain.sv
// Systolic N-tap MAC cell with loadable coefficients, valid tracking, stall,
// and a final add/shift/saturate stage; d_prop/vld_prop feed the next cell.
module idct_mac_chain
  import idct_pkg::*;
#(
  parameter int N   = 8,
  parameter int DW  = 25,
  parameter int CW  = 8,
  parameter int SHW = 4,
  parameter int AW  = acc_w(N, DW, CW)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  vld_in,
  input  logic [N*DW-1:0]       d_in,
  input  logic                  coef_we,
  input  logic [$clog2(N)-1:0]  coef_idx,
  input  logic signed [CW-1:0]  coef_wdata,
  input  logic signed [DW-1:0]  add,
  input  logic [SHW-1:0]        shift,
  input  logic                  sat_en,
  output logic                  vld_out,
  output logic signed [DW-1:0]  d_out,
  output logic                  sat_flag,
  output logic                  vld_prop,
  output logic [N*DW-1:0]       d_prop
);

  localparam int IW = $clog2(N);
  localparam int PW = DW + CW;

  logic signed [CW-1:0] coef_q [N];
  logic signed [CW-1:0] coef_d [N];
  logic signed [AW-1:0] acc_s [N-1];
  logic                 vld_s [N-1];

  for (genvar k = 0; k < N - 1; k++) begin : g_stage
    logic signed [AW-1:0] acc_in_k;
    logic                 vld_in_k;
    if (k == 0) begin : g_head
      assign acc_in_k = '0;
      assign vld_in_k = vld_in;
    end else begin : g_body
      assign acc_in_k = acc_s[k-1];
      assign vld_in_k = vld_s[k-1];
    end
    idct_mac_stage #(.DW(DW), .CW(CW), .AW(AW)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .acc_in  (acc_in_k),
      .sample  (d_in[k*DW +: DW]),
      .coef    (coef_q[k]),
      .vld_in  (vld_in_k),
      .acc_out (acc_s[k]),
      .vld_out (vld_s[k])
    );
  end

  logic signed [DW-1:0] last_smp;
  logic signed [PW-1:0] last_prod;
  logic signed [AW-1:0] sum, shifted;
  logic signed [DW-1:0] res;
  sat_t                 sat_sel;

  assign last_smp  = d_in[(N-1)*DW +: DW];
  assign last_prod = last_smp * coef_q[N-1];
  assign sum       = acc_s[N-2] + {{(AW-PW){last_prod[PW-1]}}, last_prod}
                                + {{(AW-DW){add[DW-1]}}, add};
  assign shifted   = sum >>> shift;
  assign sat_sel   = sat_check({{(SAT_W-AW){shifted[AW-1]}}, shifted}, DW, sat_en);

  always_comb begin
    case (sat_sel)
      SAT_HI:  res = {1'b0, {(DW-1){1'b1}}};
      SAT_LO:  res = {1'b1, {(DW-1){1'b0}}};
      default: res = shifted[DW-1:0];
    endcase
  end

  // Coefficient writes bypass en; indices past N-1 match nothing.
  always_comb begin
    coef_d = coef_q;
    for (int i = 0; i < N; i++) begin
      if (coef_we && coef_idx == IW'(i)) coef_d[i] = coef_wdata;
    end
  end

  logic signed [DW-1:0] d_out_q, d_out_d;
  logic                 sat_q, sat_d;
  logic                 vld_out_q, vld_out_d;
  logic                 vld_prop_q, vld_prop_d;
  logic [N*DW-1:0]      d_prop_q, d_prop_d;

  always_comb begin
    d_out_d    = d_out_q;
    sat_d      = sat_q;
    vld_out_d  = vld_out_q;
    vld_prop_d = vld_prop_q;
    d_prop_d   = d_prop_q;
    if (en) begin
      vld_prop_d = vld_in;
      d_prop_d   = d_in;
      vld_out_d  = vld_s[N-2];
      if (vld_s[N-2]) begin
        d_out_d = res;
        sat_d   = (sat_sel != SAT_NONE);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      coef_q     <= '{default: '0};
      d_out_q    <= '0;
      sat_q      <= 1'b0;
      vld_out_q  <= 1'b0;
      vld_prop_q <= 1'b0;
      d_prop_q   <= '0;
    end else begin
      coef_q     <= coef_d;
      d_out_q    <= d_out_d;
      sat_q      <= sat_d;
      vld_out_q  <= vld_out_d;
      vld_prop_q <= vld_prop_d;
      d_prop_q   <= d_prop_d;
    end
  end

  assign d_out    = d_out_q;
  assign sat_flag = sat_q;
  assign vld_out  = vld_out_q;
  assign vld_prop = vld_prop_q;
  assign d_prop   = d_prop_q;

endmodule

// File: tb/tb_idct_mac_chain.sv
// Directed bench for idct_mac_chain: skewed vectors with hand-computed sums,
// stall, reset mid-flight, in-flight coefficient write and out-of-range index.
module tb_idct_mac_chain;

  localparam int N  = 8;
  localparam int DW = 25;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, en, vld_in, coef_we, sat_en;
  logic [N*DW-1:0]      d_in;
  logic [2:0]           coef_idx;
  logic signed [CW-1:0] coef_wdata;
  logic signed [DW-1:0] add;
  logic [3:0]           shift;
  logic                 vld_out, sat_flag, vld_prop;
  logic signed [DW-1:0] d_out;
  logic [N*DW-1:0]      d_prop;

  idct_mac_chain #(.N(N), .DW(DW), .CW(CW), .SHW(4)) u_dut (
    .clk(clk), .reset(reset), .en(en), .vld_in(vld_in), .d_in(d_in),
    .coef_we(coef_we), .coef_idx(coef_idx), .coef_wdata(coef_wdata),
    .add(add), .shift(shift), .sat_en(sat_en), .vld_out(vld_out),
    .d_out(d_out), .sat_flag(sat_flag), .vld_prop(vld_prop), .d_prop(d_prop)
  );

  // Five-tap instance: its 3-bit index can address past the last tap.
  logic                 vld_in5, coef_we5, vld_out5, sat_flag5, vld_prop5;
  logic [2:0]           coef_idx5;
  logic signed [CW-1:0] coef_wdata5;
  logic [5*DW-1:0]      d_in5, d_prop5;
  logic signed [DW-1:0] d_out5;

  idct_mac_chain #(.N(5), .DW(DW), .CW(CW), .SHW(4)) u_dut5 (
    .clk(clk), .reset(reset), .en(1'b1), .vld_in(vld_in5), .d_in(d_in5),
    .coef_we(coef_we5), .coef_idx(coef_idx5), .coef_wdata(coef_wdata5),
    .add('0), .shift(4'd0), .sat_en(1'b1), .vld_out(vld_out5),
    .d_out(d_out5), .sat_flag(sat_flag5), .vld_prop(vld_prop5), .d_prop(d_prop5)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  int nv, stall_at, stall_len, rst_at, wr_slot;
  int start [4];
  logic signed [DW-1:0] vec [4][N];
  logic [2:0]           wr_idx;
  logic signed [CW-1:0] wr_val;
  longint stall_dout;
  longint res_q [$];
  longint flag_q [$];
  int     cyc_q [$];

  localparam int ROW [N] = '{64, -18, -83, 50, 64, -75, -36, 89};

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic clear_cfg();
    nv = 0; stall_at = -1; stall_len = 0; rst_at = -1; wr_slot = -1;
    wr_idx = '0; wr_val = '0; stall_dout = 0;
    for (int v = 0; v < 4; v++) begin
      start[v] = -100;
      for (int k = 0; k < N; k++) vec[v][k] = '0;
    end
  endtask

  task automatic load_coefs();
    en = 1'b0;
    for (int i = 0; i < N; i++) begin
      coef_we = 1'b1; coef_idx = 3'(i); coef_wdata = 8'(ROW[i]);
      tick();
    end
    coef_we = 1'b0;
    en = 1'b1;
  endtask

  task automatic drive_slot(input int s);
    vld_in = 1'b0;
    d_in = '0;
    for (int v = 0; v < nv; v++) begin
      if (start[v] == s) vld_in = 1'b1;
      for (int k = 0; k < N; k++)
        if (s - start[v] == k) d_in[k*DW +: DW] = vec[v][k];
    end
  endtask

  task automatic run(input int slots);
    int base;
    logic [N*DW-1:0] held_d;
    logic held_v;
    res_q.delete(); flag_q.delete(); cyc_q.delete();
    base = cyc;
    for (int s = 0; s < slots; s++) begin
      if (s == stall_at) begin
        held_d = d_in; held_v = vld_in;
        en = 1'b0; d_in = '1; vld_in = 1'b1;
        for (int j = 0; j < stall_len; j++) begin
          tick();
          chk("stall_vld_prop", longint'(vld_prop), longint'(held_v));
          chk("stall_d_prop", longint'(d_prop == held_d), 1);
          chk("stall_vld_out", longint'(vld_out), 1);
          chk("stall_d_out", d_out, stall_dout);
        end
        en = 1'b1;
      end
      drive_slot(s);
      coef_we = (s == wr_slot); coef_idx = wr_idx; coef_wdata = wr_val;
      reset = (s == rst_at);
      tick();
      coef_we = 1'b0; reset = 1'b0;
      if (s == rst_at) begin
        chk("rst_vld_out", longint'(vld_out), 0);
        chk("rst_d_out", d_out, 0);
        chk("rst_sat_flag", longint'(sat_flag), 0);
        chk("rst_vld_prop", longint'(vld_prop), 0);
        chk("rst_d_prop", longint'(d_prop == '0), 1);
      end else if (vld_out) begin
        res_q.push_back(d_out);
        flag_q.push_back(longint'(sat_flag));
        cyc_q.push_back(cyc - base);
      end
    end
  endtask

  task automatic expect1(input string tag, input longint val, input longint flag);
    chk({tag, "_cnt"}, res_q.size(), 1);
    if (res_q.size() == 1) begin
      chk({tag, "_val"}, res_q[0], val);
      chk({tag, "_sat"}, flag_q[0], flag);
      chk({tag, "_lat"}, cyc_q[0], 8);
    end
  endtask

  task automatic ones_vec();
    clear_cfg();
    nv = 1; start[0] = 0;
    for (int k = 0; k < N; k++) vec[0][k] = 25'sd1;
  endtask

  initial begin
    int lat;
    bit seen;
    reset = 1'b1; en = 1'b0; vld_in = 1'b0; d_in = '0; coef_we = 1'b0;
    coef_idx = '0; coef_wdata = '0; add = '0; shift = '0; sat_en = 1'b1;
    vld_in5 = 1'b0; coef_we5 = 1'b0; coef_idx5 = '0; coef_wdata5 = '0;
    d_in5 = {5{25'd1}};
    tick(); tick();
    reset = 1'b0;
    chk("reset_vld_out", longint'(vld_out), 0);
    chk("reset_d_out", d_out, 0);
    chk("reset_sat_flag", longint'(sat_flag), 0);
    chk("reset_vld_prop", longint'(vld_prop), 0);
    chk("reset_d_prop", longint'(d_prop == '0), 1);

    load_coefs();
    ones_vec();
    run(12);
    expect1("ones", 55, 0);

    clear_cfg(); nv = 1; start[0] = 0; vec[0][0] = 25'sd100;
    add = 25'sd64; shift = 4'd7;
    run(12);
    expect1("round", 50, 0);

    add = '0; shift = '0;
    vec[0][0] = 25'sd16777215;
    run(12);
    expect1("sat", 16777215, 1);
    sat_en = 1'b0;
    run(12);
    expect1("trunc", -64, 0);
    sat_en = 1'b1;

    clear_cfg(); nv = 3;
    for (int v = 0; v < 3; v++) start[v] = v;
    for (int k = 0; k < N; k++) begin
      vec[0][k] = 25'sd1;
      vec[1][k] = 25'(k + 1);
      vec[2][k] = (k % 2 == 0) ? 25'sd10 : -25'sd10;
    end
    stall_at = 8; stall_len = 3; stall_dout = 55;
    run(16);
    chk("b2b_cnt", res_q.size(), 3);
    if (res_q.size() == 3) begin
      chk("b2b_v0", res_q[0], 55);
      chk("b2b_v1", res_q[1], 309);
      chk("b2b_v2", res_q[2], -370);
      chk("b2b_c0", cyc_q[0], 8);
      chk("b2b_c1", cyc_q[1], 12);
      chk("b2b_c2", cyc_q[2], 13);
    end

    ones_vec();
    rst_at = 4; wr_slot = 4; wr_idx = 3'd0; wr_val = 8'sd64;
    run(12);
    chk("rst_drop_cnt", res_q.size(), 0);
    ones_vec();
    run(12);
    expect1("zero_coef", 0, 0);

    load_coefs();
    ones_vec();
    wr_slot = 3; wr_idx = 3'd7; wr_val = 8'sd0;
    run(12);
    expect1("late_wr", -34, 0);

    for (int i = 0; i < 8; i++) begin
      coef_we5 = 1'b1; coef_idx5 = 3'(i);
      coef_wdata5 = (i < 5) ? 8'(i + 1) : 8'sd100;
      tick();
    end
    coef_we5 = 1'b0;
    vld_in5 = 1'b1;
    tick();
    vld_in5 = 1'b0;
    lat = 1; seen = 1'b0;
    while (!seen && lat < 12) begin
      if (vld_out5) seen = 1'b1;
      else begin tick(); lat++; end
    end
    chk("n5_seen", longint'(seen), 1);
    chk("n5_lat", lat, 5);
    chk("n5_val", d_out5, 15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
